// File: rtl/gemac_tx_arb_pkg.sv
// Shared constants, state encoding and helpers for the GEMAC TX client arbiter.
package gemac_tx_arb_pkg;

    localparam int CNT_W   = 16;
    localparam int GRANT_W = 3;
    localparam int GAP_W   = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SEND  = SEND,
        ST_DRAIN = DRAIN,
        ST_GAP   = GAP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/gemac_tx_arb_if.sv
// Byte-stream bundle between the requesters, the arbiter and the MAC client port.
// master = the arbiter; slave = the surrounding sources and MAC.
interface gemac_tx_arb_if #(parameter int NUM_SRC = 2);
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_eof;
    logic [NUM_SRC-1:0]   src_ack;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_error;
    logic                 tx_ack;

    modport master (
        input  src_data, src_valid, src_eof, tx_ack,
        output src_ack, tx_data, tx_valid, tx_error
    );

    modport slave (
        output src_data, src_valid, src_eof, tx_ack,
        input  src_ack, tx_data, tx_valid, tx_error
    );
endinterface

// File: rtl/gemac_tx_arb_rr_pick.sv
// Requester picker: first request at or after ptr+1 (mod NUM_SRC), or plain
// lowest-index priority when GEMAC_TX_ARB_STRICT_PRIO_EN is defined.
module gemac_tx_arb_rr_pick
    import gemac_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] idx,
    output logic               found
);

`ifdef GEMAC_TX_ARB_STRICT_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest requesting index wins; scanning downwards leaves the lowest hit last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx   = GRANT_W'(k);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end
`else
    int   cand;
    logic hit;

    // Walk the ring starting just after the last served source, wrapping at NUM_SRC.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        hit   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (int'(ptr) + 1 + k) % NUM_SRC;
            hit  = 1'b0;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j == cand) begin
                    hit = req[j];
                end else begin
                    hit = hit;
                end
            end
            if (!found && hit) begin
                idx   = GRANT_W'(cand);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end
`endif

endmodule

// File: rtl/gemac_tx_arb.sv
// Frame-granular arbiter in front of the GEMAC TX client port (tx_clk domain).
// Whole frames only, minimum client-side gap, mid-frame underrun -> tx_error abort.
// Optional build macro: GEMAC_TX_ARB_STRICT_PRIO_EN (strict priority pick instead of round-robin).
module gemac_tx_arb
    import gemac_tx_arb_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    gemac_tx_arb_if.master     bus,
    output logic [GRANT_W-1:0] grant,
    output logic               busy,
    output logic [CNT_W-1:0]   frame_count,
    output logic [CNT_W-1:0]   underrun_count
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t               state_r, state_s;
    logic [GRANT_W-1:0]   grant_r, grant_s;
    logic [GRANT_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
    logic                 acked_r, acked_s;
    logic                 busy_r;
    logic [CNT_W-1:0]     frame_count_r, underrun_count_r;
    logic                 frame_inc_s, under_inc_s;
    logic [GRANT_W-1:0]   pick_idx_s;
    logic                 pick_found_s;
    logic [7:0]           sel_data_s, tx_data_s;
    logic                 sel_valid_s, sel_eof_s;
    logic                 tx_valid_s, tx_error_s, ack_sel_s;
    logic [NUM_SRC-1:0]   src_ack_s;

    gemac_tx_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
        .req   (bus.src_valid),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Route the granted source's byte, valid and eof onto the shared path.
    always_comb begin
        sel_data_s  = 8'd0;
        sel_valid_s = 1'b0;
        sel_eof_s   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_r == GRANT_W'(i)) begin
                sel_data_s  = bus.src_data[8*i +: 8];
                sel_valid_s = bus.src_valid[i];
                sel_eof_s   = bus.src_eof[i];
            end else begin
                sel_data_s  = sel_data_s;
                sel_valid_s = sel_valid_s;
                sel_eof_s   = sel_eof_s;
            end
        end
    end

    // Next-state and handshake outputs; tx_ack only ever reaches a source in SEND.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        gap_cnt_s   = gap_cnt_r;
        acked_s     = acked_r;
        frame_inc_s = 1'b0;
        under_inc_s = 1'b0;
        tx_valid_s  = 1'b0;
        tx_error_s  = 1'b0;
        tx_data_s   = 8'd0;
        ack_sel_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_s = pick_idx_s;
                    acked_s = 1'b0;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                tx_data_s = sel_data_s;
                if (sel_valid_s) begin
                    tx_valid_s = 1'b1;
                    ack_sel_s  = bus.tx_ack;
                    if (bus.tx_ack) begin
                        acked_s = 1'b1;
                        if (sel_eof_s) begin
                            frame_inc_s = 1'b1;
                            rr_ptr_s    = grant_r;
                            gap_cnt_s   = GAP_LOAD;
                            state_s     = ST_GAP;
                        end else begin
                            state_s = ST_SEND;
                        end
                    end else begin
                        state_s = ST_SEND;
                    end
                end else if (acked_r) begin
                    // Frame already started at the MAC: abort it with one error beat.
                    tx_valid_s  = 1'b1;
                    tx_error_s  = 1'b1;
                    under_inc_s = 1'b1;
                    state_s     = ST_DRAIN;
                end else begin
                    // Nothing reached the MAC yet, so the request is simply withdrawn.
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                ack_sel_s = sel_valid_s;
                if (sel_valid_s && sel_eof_s) begin
                    rr_ptr_s  = grant_r;
                    gap_cnt_s = GAP_LOAD;
                    state_s   = ST_GAP;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Fan the consume strobe back to the granted source only.
    always_comb begin
        src_ack_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_r == GRANT_W'(i)) begin
                src_ack_s[i] = ack_sel_s;
            end else begin
                src_ack_s[i] = 1'b0;
            end
        end
    end

    // State, grant, pointer and statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            grant_r          <= '0;
            rr_ptr_r         <= '0;
            gap_cnt_r        <= '0;
            acked_r          <= 1'b0;
            busy_r           <= 1'b0;
            frame_count_r    <= '0;
            underrun_count_r <= '0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            rr_ptr_r  <= rr_ptr_s;
            gap_cnt_r <= gap_cnt_s;
            acked_r   <= acked_s;
            busy_r    <= (state_s != ST_IDLE);
            if (frame_inc_s) begin
                frame_count_r <= frame_count_r + CNT_W'(1);
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (under_inc_s) begin
                underrun_count_r <= sat_inc(underrun_count_r);
            end else begin
                underrun_count_r <= underrun_count_r;
            end
        end
    end

    assign bus.tx_data     = tx_data_s;
    assign bus.tx_valid    = tx_valid_s;
    assign bus.tx_error    = tx_error_s;
    assign bus.src_ack     = src_ack_s;
    assign grant           = grant_r;
    assign busy            = busy_r;
    assign frame_count     = frame_count_r;
    assign underrun_count  = underrun_count_r;

endmodule

// File: tb/tb_gemac_tx_arb.sv
// Directed bench for gemac_tx_arb: bench-side byte sources plus a stalling MAC.
module tb_gemac_tx_arb;

    localparam int NS   = 2;
    localparam int GAPC = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  grant;
    logic        busy;
    logic [15:0] frame_count, underrun_count;

    gemac_tx_arb_if #(.NUM_SRC(NS)) bus ();

    gemac_tx_arb #(.NUM_SRC(NS), .GAP_CYCLES(GAPC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .grant          (grant),
        .busy           (busy),
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // source model: frame length, byte position, frames left, underrun hole
    int len[NS], pos[NS], frames[NS], drop_at[NS], drop_len[NS], drop_cnt[NS];
    int stall;

    // observations
    int n_ack[NS];
    int n_drain_ack, n_bad, n_err, n_err_nov;
    int first_valid, first_ack, last_eof, low_run;
    logic prev_valid, seen_valid;
    int grant_q[$];
    int gap_q[$];
    logic          o_valid, o_error, o_busy;
    logic [7:0]    o_data;
    logic [2:0]    o_grant;
    logic [NS-1:0] o_ack;

    function automatic logic [7:0] exp_byte(input int i, input int p);
        return 8'(i * 64 + p);
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < NS; i++) n_ack[i] = 0;
        n_drain_ack = 0; n_bad = 0; n_err = 0; n_err_nov = 0;
        first_valid = -1; first_ack = -1; last_eof = -1; low_run = 0;
        prev_valid = 1'b0; seen_valid = 1'b0;
        grant_q.delete();
        gap_q.delete();
    endtask

    // One clock: drive sources and MAC at the falling edge, sample 1ns later.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            logic v;
            v = (frames[i] > 0);
            if (v && pos[i] == drop_at[i] && drop_cnt[i] < drop_len[i]) begin
                v = 1'b0;
                drop_cnt[i]++;
            end
            bus.src_valid[i]       = v;
            bus.src_data[8*i +: 8] = exp_byte(i, pos[i]);
            bus.src_eof[i]         = v && (pos[i] == len[i] - 1);
        end
        bus.tx_ack = (stall == 0);
        #1;
        o_valid = bus.tx_valid; o_error = bus.tx_error; o_data = bus.tx_data;
        o_ack = bus.src_ack; o_grant = grant; o_busy = busy;
        if (o_valid && !prev_valid) begin
            grant_q.push_back(int'(o_grant));
            if (seen_valid) gap_q.push_back(low_run);
            if (first_valid < 0) first_valid = cyc;
            seen_valid = 1'b1;
        end
        if (!o_valid) low_run++; else low_run = 0;
        prev_valid = o_valid;
        if (o_error) begin
            n_err++;
            if (!o_valid) n_err_nov++;
        end
        if (o_valid && !o_error) begin
            if (int'(o_grant) >= NS) n_bad++;
            else if (o_data !== exp_byte(int'(o_grant), pos[int'(o_grant)])) n_bad++;
        end
        if (o_ack != '0 && !o_busy) n_bad++;
        for (int i = 0; i < NS; i++) begin
            if (o_ack[i]) begin
                if (int'(o_grant) != i) n_bad++;
                n_ack[i]++;
                if (!o_valid) n_drain_ack++;
                else if (first_ack < 0) first_ack = cyc;
                if (pos[i] == len[i] - 1) begin
                    frames[i]--; pos[i] = 0; drop_cnt[i] = 0; last_eof = cyc;
                end else begin
                    pos[i]++;
                end
            end
        end
        if (o_valid && stall > 0) stall--;
        cyc++;
    endtask

    task automatic run_idle(input int max, output logic to);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(frames[0] == 0 && frames[1] == 0 && !o_busy) && k < max);
        to = !(frames[0] == 0 && frames[1] == 0 && !o_busy);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.src_valid = '0; bus.src_eof = '0; bus.src_data = '0; bus.tx_ack = 1'b1;
        for (int i = 0; i < NS; i++) begin
            len[i] = 1; pos[i] = 0; frames[i] = 0; drop_at[i] = -1; drop_len[i] = 0; drop_cnt[i] = 0;
        end
        stall = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if ({bus.tx_valid, bus.tx_error, busy} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {bus.tx_valid, bus.tx_error, busy}); else n_pass++;
        n_checks++; if (bus.src_ack !== 2'b00) $display("FAIL reset_src_ack: got %b expected 00", bus.src_ack); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); else n_pass++;
        n_checks++; if (grant !== 3'd0) $display("FAIL reset_grant: got %0d expected 0", grant); else n_pass++;
        n_checks++; if ({frame_count, underrun_count} !== 32'd0) $display("FAIL reset_counters: got %h expected 0", {frame_count, underrun_count}); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int c0;
        logic to;
        clear_stats();
        len[0] = 64; frames[0] = 1; stall = 8;
        c0 = cyc;
        run_idle(200, to);
        n_checks++; if (to !== 1'b0) $display("FAIL single_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (first_valid !== c0 + 1) $display("FAIL single_latency: got %0d expected %0d", first_valid - c0, 1); else n_pass++;
        n_checks++; if (first_ack - first_valid !== 8) $display("FAIL single_stall: got %0d expected 8", first_ack - first_valid); else n_pass++;
        n_checks++; if (n_ack[0] !== 64) $display("FAIL single_acks: got %0d expected 64", n_ack[0]); else n_pass++;
        n_checks++; if (n_bad !== 0) $display("FAIL single_data: got %0d bad beats expected 0", n_bad); else n_pass++;
        n_checks++; if (frame_count !== 16'd1) $display("FAIL single_frame_count: got %0d expected 1", frame_count); else n_pass++;
        // two GAP cycles then the idle cycle where busy has dropped
        n_checks++; if ((cyc - 1) - last_eof !== GAPC + 1) $display("FAIL single_gap: got %0d expected %0d", (cyc - 1) - last_eof, GAPC + 1); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_g[6] = '{1, 0, 1, 0, 1, 0};
        logic to;
        clear_stats();
        len[0] = 4; len[1] = 4; frames[0] = 3; frames[1] = 3; stall = 0;
        run_idle(300, to);
        n_checks++; if (to !== 1'b0) $display("FAIL rr_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (grant_q.size() !== 6) $display("FAIL rr_frames: got %0d expected 6", grant_q.size()); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = (k < grant_q.size()) ? grant_q[k] : -1;
            n_checks++; if (g !== exp_g[k]) $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, g, exp_g[k]); else n_pass++;
        end
        // gap between frames: GAP_CYCLES plus the arbitration cycle in IDLE
        for (int k = 0; k < gap_q.size(); k++) begin
            n_checks++; if (gap_q[k] !== GAPC + 1) $display("FAIL rr_gap[%0d]: got %0d expected %0d", k, gap_q[k], GAPC + 1); else n_pass++;
        end
        n_checks++; if ({n_ack[0], n_ack[1], n_drain_ack, n_bad} !== {32'd12, 32'd12, 32'd0, 32'd0}) $display("FAIL rr_acks: got %0d/%0d drain %0d bad %0d expected 12/12 0 0", n_ack[0], n_ack[1], n_drain_ack, n_bad); else n_pass++;
        n_checks++; if (frame_count !== 16'd7) $display("FAIL rr_frame_count: got %0d expected 7", frame_count); else n_pass++;
    endtask

    task automatic test_underrun();
        logic to;
        clear_stats();
        len[1] = 15; frames[1] = 1; drop_at[1] = 10; drop_len[1] = 2; stall = 0;
        run_idle(200, to);
        drop_at[1] = -1;
        n_checks++; if (to !== 1'b0) $display("FAIL underrun_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (n_err !== 1 || n_err_nov !== 0) $display("FAIL underrun_error_beat: got %0d (%0d without valid) expected 1 (0)", n_err, n_err_nov); else n_pass++;
        n_checks++; if (underrun_count !== 16'd1) $display("FAIL underrun_count: got %0d expected 1", underrun_count); else n_pass++;
        n_checks++; if (n_drain_ack !== 5 || n_ack[1] !== 15) $display("FAIL underrun_drain: got %0d drained %0d total expected 5 15", n_drain_ack, n_ack[1]); else n_pass++;
        n_checks++; if (frame_count !== 16'd7) $display("FAIL underrun_frame_count: got %0d expected 7", frame_count); else n_pass++;
        n_checks++; if (n_bad !== 0) $display("FAIL underrun_data: got %0d expected 0", n_bad); else n_pass++;
    endtask

    task automatic test_withdraw();
        int c0;
        logic to;
        clear_stats();
        len[0] = 8; frames[0] = 1; stall = 100;
        repeat (4) step();
        frames[0] = 0;
        step();
        step();
        n_checks++; if (o_busy !== 1'b0) $display("FAIL withdraw_idle: got busy %b expected 0", o_busy); else n_pass++;
        n_checks++; if (n_err !== 0 || n_ack[0] !== 0) $display("FAIL withdraw_error: got err %0d acks %0d expected 0 0", n_err, n_ack[0]); else n_pass++;
        n_checks++; if ({frame_count, underrun_count} !== {16'd7, 16'd1}) $display("FAIL withdraw_counters: got %0d %0d expected 7 1", frame_count, underrun_count); else n_pass++;
        clear_stats();
        frames[0] = 1; stall = 0;
        c0 = cyc;
        run_idle(100, to);
        n_checks++; if (to !== 1'b0 || first_valid !== c0 + 1) $display("FAIL withdraw_regrant: got latency %0d timeout %b expected 1 0", first_valid - c0, to); else n_pass++;
        n_checks++; if (frame_count !== 16'd8) $display("FAIL withdraw_frame_count: got %0d expected 8", frame_count); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int k;
        int c0;
        logic to;
        clear_stats();
        len[1] = 20; frames[1] = 1; stall = 0;
        k = 0;
        while (n_ack[1] < 5 && k < 50) begin
            step();
            k++;
        end
        n_checks++; if (n_ack[1] !== 5 || grant !== 3'd1) $display("FAIL midrst_setup: got acks %0d grant %0d expected 5 1", n_ack[1], grant); else n_pass++;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if ({bus.tx_valid, bus.tx_error, busy, bus.src_ack} !== 5'b0) $display("FAIL midrst_outputs: got %b expected 00000", {bus.tx_valid, bus.tx_error, busy, bus.src_ack}); else n_pass++;
        n_checks++; if (grant !== 3'd0 || bus.tx_data !== 8'h00) $display("FAIL midrst_grant: got %0d data %h expected 0 00", grant, bus.tx_data); else n_pass++;
        n_checks++; if ({frame_count, underrun_count} !== 32'd0) $display("FAIL midrst_counters: got %0d %0d expected 0 0", frame_count, underrun_count); else n_pass++;
        frames[1] = 0; pos[1] = 0; bus.src_valid = '0; bus.src_eof = '0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        len[1] = 4; frames[1] = 1;
        c0 = cyc;
        run_idle(100, to);
        n_checks++; if (to !== 1'b0 || first_valid !== c0 + 1) $display("FAIL midrst_regrant: got latency %0d timeout %b expected 1 0", first_valid - c0, to); else n_pass++;
        n_checks++; if (grant_q.size() !== 1 || n_ack[1] !== 4 || n_bad !== 0) $display("FAIL midrst_frame: got frames %0d acks %0d bad %0d expected 1 4 0", grant_q.size(), n_ack[1], n_bad); else n_pass++;
        n_checks++; if (frame_count !== 16'd1) $display("FAIL midrst_frame_count: got %0d expected 1", frame_count); else n_pass++;
    endtask

`ifdef GEMAC_TX_ARB_STRICT_PRIO_EN
    task automatic test_pick_order();
        logic to;
        clear_stats();
        len[0] = 3; len[1] = 3; frames[0] = 4; frames[1] = 4; stall = 0;
        run_idle(300, to);
        n_checks++; if (to !== 1'b0 || grant_q.size() !== 8) $display("FAIL prio_frames: got %0d timeout %b expected 8 0", grant_q.size(), to); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k < grant_q.size()) ? grant_q[k] : -1;
            n_checks++; if (g !== 0) $display("FAIL prio_grant[%0d]: got %0d expected 0", k, g); else n_pass++;
        end
    endtask
`else
    task automatic test_pick_order();
        int exp_g[4] = '{0, 1, 0, 1};
        logic to;
        clear_stats();
        // pointer rests on source 1 after the previous frame, so source 0 goes first
        len[0] = 3; len[1] = 3; frames[0] = 2; frames[1] = 2; stall = 0;
        run_idle(200, to);
        n_checks++; if (to !== 1'b0 || grant_q.size() !== 4) $display("FAIL ptr_frames: got %0d timeout %b expected 4 0", grant_q.size(), to); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k < grant_q.size()) ? grant_q[k] : -1;
            n_checks++; if (g !== exp_g[k]) $display("FAIL ptr_grant[%0d]: got %0d expected %0d", k, g, exp_g[k]); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_underrun();
        test_withdraw();
        test_reset_mid_frame();
        test_pick_order();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gemac_tx_arb.md
Name: gemac_tx_arb

Overview:
- Frame-granular arbiter sharing the single GEMAC TX client byte interface (tx_data/tx_valid/tx_error/tx_ack) among NUM_SRC byte-stream requesters, e.g. the VITA data path, the control responder and the ARP/ping responder.
- Sits in the tx_clk domain directly in front of the MAC.
- Never interleaves frames, inserts a minimum client-side gap between frames, and converts mid-frame source underrun into a MAC tx_error abort.
- Keeps frame and underrun counters for the settings bus.

Parameters:
- NUM_SRC, 2, number of requesters (2..8).
- GAP_CYCLES, 2, minimum cycles tx_valid held low between frames (1..15).

Ports:
- clk  in  1  tx_clk from the MAC.
- reset_n  in  1  asynchronous, active-low reset.
- src_data  in  8*NUM_SRC  byte per source; source i uses [8i+7:8i].
- src_valid  in  NUM_SRC  byte valid / frame request per source.
- src_eof  in  NUM_SRC  qualifies the last byte of a frame.
- src_ack  out  NUM_SRC  byte consumed from source i.
- tx_data  out  8  to MAC.
- tx_valid  out  1  to MAC.
- tx_error  out  1  to MAC.
- tx_ack  in  1  from MAC; byte taken this cycle.
- grant  out  3  index of the current or last granted source.
- busy  out  1  high whenever state is not IDLE.
- frame_count  out  16  frames completed cleanly; wraps at 0xFFFF->0.
- underrun_count  out  16  aborted frames; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, grant=0, rr pointer=0, counters=0; tx_valid, tx_error, src_ack, busy all 0; tx_data=0.
- States: IDLE, SEND, DRAIN, GAP.
- IDLE:
  - Any src_valid high: pick the first requester at or after rr pointer+1 (mod NUM_SRC) and latch it into grant.
  - Go to SEND next cycle. Arbitration latency is 1 cycle; tx_valid rises in the cycle after the request is seen.
- SEND:
  - tx_valid = src_valid[grant]; tx_data = src_data[grant]; tx_error = 0.
  - src_ack[grant] = tx_ack; all other src_ack = 0.
  - Data must be held until tx_ack; the preamble stall before the first tx_ack is unbounded.
  - tx_ack with src_eof[grant]: frame_count++, rr pointer <= grant, go to GAP.
  - src_valid[grant] low while in SEND, after at least one tx_ack: underrun.
    - Hold tx_valid=1 and drive tx_error=1 for exactly one cycle.
    - underrun_count++, then go to DRAIN.
  - src_valid[grant] low before any tx_ack: not an error; go back to IDLE without a gap (request withdrawn).
- DRAIN:
  - tx_valid=0; src_ack[grant] = src_valid[grant], discarding bytes.
  - On the acked eof byte: rr pointer <= grant, go to GAP.
- GAP: tx_valid=0 for GAP_CYCLES cycles (counter), then go to IDLE.
- Simultaneous events:
  - Requests from several sources: round-robin order.
  - eof accepted in the same cycle as src_valid falling is impossible, since eof is qualified by valid.
- tx_ack arriving outside SEND is ignored and never forwarded.
- Reset asserted mid-frame: outputs drop immediately. The MAC sees tx_valid fall and ends the frame; the source must also be reset.
- A source is never granted a new frame before its previous eof was acked or drained.

Optional Feature:
- Macro: GEMAC_TX_ARB_STRICT_PRIO_EN.
- When defined, the IDLE pick is strict priority (lowest index wins) and the rr pointer is unused.
- When undefined, round-robin as above.
- Default build: undefined.

Decomposition:
- Package gemac_tx_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, SEND=2'd1, DRAIN=2'd2, GAP=2'd3);
  - the counter width constant (16);
  - the grant width constant (3).
- One sub-module, rr_pick (combinational):
  - inputs: request vector and pointer;
  - outputs: index and found flag;
  - handles wrap-around;
  - compiled to a plain priority encoder under GEMAC_TX_ARB_STRICT_PRIO_EN.

Test Plan:
- Src0 sends a 64-byte frame; MAC stalls tx_ack for 8 cycles -> tx_data steady until the first ack; 64 acks; frame_count=1; tx_valid low for 2 cycles after eof.
- Src0 and src1 request simultaneously and continuously, 3 frames each -> grant sequence 1,0,1,0,1,0; no interleaved bytes; gap of 2 cycles between frames.
- Src1 drops valid after byte 10 acked -> one cycle of tx_valid=1 with tx_error=1; underrun_count=1; remaining 5 bytes drained through src_ack with tx_valid=0; frame_count unchanged.
- Src0 withdraws valid before the first tx_ack -> back to IDLE, no tx_error, counters unchanged.
- reset_n pulsed low mid-frame -> all outputs 0 in the same cycle; grant=0; counters=0; the next request is granted normally.
- Build with GEMAC_TX_ARB_STRICT_PRIO_EN, src0 and src1 always requesting -> src0 granted for 4 consecutive frames.
